sq_check_16bit: RTL and testbench



---
 rtl/sq_check_16bit_if.sv | 25 ++
 rtl/sq_check_16bit.sv | 112 +++++++++++
 tb/tb_sq_check_16bit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sq_check_16bit_if.sv
// Request/result bundle for the fixed-point squarer and residual checker.
// master drives the root and reference; slave returns the square, residual and status.
interface sq_check_16bit_if #(
    parameter int N = 16
);
    logic             start_i;
    logic [N:0]       yint_i;
    logic [N-1:0]     ydec_i;
    logic [2*N:0]     xref_i;
    logic             busy_o;
    logic             done_o;
    logic [2*N+2:0]   sq_o;
    logic [2*N+3:0]   diff_o;
    logic             within_o;

    modport master (
        output start_i, yint_i, ydec_i, xref_i,
        input  busy_o, done_o, sq_o, diff_o, within_o
    );

    modport slave (
        input  start_i, yint_i, ydec_i, xref_i,
        output busy_o, done_o, sq_o, diff_o, within_o
    );
endinterface

// File: rtl/sq_check_16bit.sv
// Squares a Q(N+1).N root back to a rounded integer with a bit-serial shift-add
// multiplier, then reports the signed residual against a reference square.
module sq_check_16bit #(
    parameter int N   = 16,
    parameter int TOL = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    sq_check_16bit_if.slave bus
);
    localparam int YW = 2 * N + 1;
    localparam int AW = 4 * N + 2;
    localparam int SW = 2 * N + 3;
    localparam int DW = 2 * N + 4;
    localparam int CW = $clog2(2 * N + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * N);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND,
        DONE
    } state_t;

    state_t          state;
    logic [YW-1:0]   mult;
    logic [AW-1:0]   mcand;
    logic [AW-1:0]   acc;
    logic [YW-1:0]   xref;
    logic [CW-1:0]   cnt;

    logic            busy_q;
    logic            done_q;
    logic [SW-1:0]   sq_q;
    logic [DW-1:0]   diff_q;
    logic            within_q;

    logic [SW-1:0]   sq_n;
    logic [DW-1:0]   diff_n;
    logic [DW-1:0]   mag_n;
    logic            within_n;
    logic [YW-1:0]   y_in;

    assign y_in = {bus.yint_i, bus.ydec_i};

    // Adding 2^(2N-1) then dropping 2N bits is the same as adding bit 2N-1.
    assign sq_n = {1'b0, acc[AW-1:2*N]}
                + {{(SW-1){1'b0}}, acc[2*N-1]};

    assign diff_n   = {1'b0, sq_n} - {3'b000, xref};
    assign mag_n    = diff_n[DW-1] ? (~diff_n + 1'b1) : diff_n;
    assign within_n = (mag_n <= DW'(TOL));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mult     <= '0;
            mcand    <= '0;
            acc      <= '0;
            xref     <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sq_q     <= '0;
            diff_q   <= '0;
            within_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        mult   <= y_in;
                        mcand  <= {{(AW-YW){1'b0}}, y_in};
                        acc    <= '0;
                        xref   <= bus.xref_i;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    if (mult[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    sq_q     <= sq_n;
                    diff_q   <= diff_n;
                    within_q <= within_n;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.sq_o     = sq_q;
    assign bus.diff_o   = diff_q;
    assign bus.within_o = within_q;
endmodule

// File: tb/tb_sq_check_16bit.sv
// Randomized and directed bench for sq_check_16bit against an
// arithmetic reference (true product, round half up, signed residual).
module tb_sq_check_16bit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [34:0] prev_sq;
    logic [16:0] nx_yi;
    logic [15:0] nx_yd;
    logic [32:0] nx_xr;

    sq_check_16bit_if #(.N(16)) bus ();

    sq_check_16bit #(.N(16), .TOL(1)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] m_sq(input logic [32:0] y);
        logic [67:0] p;
        p = 68'(y) * 68'(y);
        p = p + (68'd1 << 31);
        return p[66:32];
    endfunction

    function automatic logic [35:0] m_diff(input logic [34:0] s,
                                           input logic [32:0] x);
        return 36'(s) - 36'(x);
    endfunction

    function automatic bit m_within(input logic [35:0] d);
        longint v;
        v = longint'($signed(d));
        if (v < 0) v = -v;
        return v <= 1;
    endfunction

    task automatic scramble();
        bus.yint_i = 17'($urandom);
        bus.ydec_i = 16'($urandom);
        bus.xref_i = {1'($urandom), 32'($urandom)};
    endtask

    task automatic op(input logic [16:0] yi, input logic [15:0] yd,
                      input logic [32:0] xr, input bit chained,
                      input bit pulse, input bit hold);
        logic [34:0] es;
        logic [35:0] ed;
        bit          ew;
        int          lat;
        es = m_sq({yi, yd});
        ed = m_diff(es, xr);
        ew = m_within(ed);
        if (!chained) begin
            @(negedge clk);
            bus.yint_i  = yi;
            bus.ydec_i  = yd;
            bus.xref_i  = xr;
            bus.start_i = 1'b1;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        scramble();
        chk("busy_start", 64'(bus.busy_o), 64'd1);
        lat = 0;
        while (!bus.done_o && lat < 60) begin
            bus.start_i = pulse && (lat == 5 || lat == 20);
            scramble();
            if (lat == 10) chk("hold_sq", 64'(bus.sq_o), 64'(prev_sq));
            @(negedge clk);
            lat++;
        end
        bus.start_i = 1'b0;
        chk("latency", 64'(lat), 64'd34);
        chk("sq", 64'(bus.sq_o), 64'(es));
        chk("diff", 64'(bus.diff_o), 64'(ed));
        chk("within", 64'(bus.within_o), 64'(ew));
        chk("busy_done", 64'(bus.busy_o), 64'd0);
        prev_sq = es;
        if (hold) begin
            bus.yint_i  = nx_yi;
            bus.ydec_i  = nx_yd;
            bus.xref_i  = nx_xr;
            bus.start_i = 1'b1;
        end
        @(negedge clk);
        chk("done_pulse", 64'(bus.done_o), 64'd0);
        if (!hold) chk("sq_keep", 64'(bus.sq_o), 64'(es));
    endtask

    initial begin
        logic [16:0] yi;
        logic [15:0] yd;
        logic [32:0] xr;
        logic [34:0] s;
        n_vec   = 0;
        n_err   = 0;
        prev_sq = '0;
        nx_yi   = '0;
        nx_yd   = '0;
        nx_xr   = '0;
        rst     = 1'b0;
        bus.start_i = 1'b1;
        bus.yint_i  = 17'd3;
        bus.ydec_i  = 16'd0;
        bus.xref_i  = 33'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 64'(bus.busy_o), 64'd0);
            chk("rst_done", 64'(bus.done_o), 64'd0);
            chk("rst_sq", 64'(bus.sq_o), 64'd0);
            chk("rst_diff", 64'(bus.diff_o), 64'd0);
            chk("rst_within", 64'(bus.within_o), 64'd0);
        end
        bus.start_i = 1'b0;
        rst = 1'b1;

        op(17'd3, 16'h0000, 33'd9, 0, 0, 0);
        op(17'd5, 16'h0000, 33'd25, 0, 0, 0);
        op(17'd1, 16'h8000, 33'd2, 0, 0, 0);
        op(17'd2, 16'h8000, 33'd6, 0, 0, 0);
        op(17'd1, 16'h6A09, 33'd2, 0, 0, 0);
        op(17'd3, 16'h0000, 33'd12, 0, 0, 0);
        op(17'h1FFFF, 16'hFFFF, 33'd0, 0, 0, 0);
        op(17'd7, 16'h1234, 33'd50, 0, 1, 0);

        nx_yi = 17'd4;
        nx_yd = 16'h4000;
        nx_xr = 33'd18;
        op(17'd6, 16'h0000, 33'd37, 0, 0, 1);
        op(17'd4, 16'h4000, 33'd18, 1, 0, 0);

        @(negedge clk);
        bus.yint_i  = 17'd9;
        bus.ydec_i  = 16'h0;
        bus.xref_i  = 33'd81;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_sq", 64'(bus.sq_o), 64'd0);
        prev_sq = '0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (bus.done_o) seen = 1'b1;
            end
            chk("abort_nodone", 64'(seen), 64'd0);
        end
        op(17'd9, 16'h0000, 33'd81, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            yi = (k % 2 == 0) ? 17'($urandom_range(0, 255)) : 17'($urandom);
            yd = 16'($urandom);
            s  = m_sq({yi, yd});
            if (s < 35'h1_0000_0004 && $urandom_range(0, 1) == 1)
                xr = 33'(s + 35'($urandom_range(0, 4)) - 35'd2);
            else
                xr = {1'($urandom), 32'($urandom)};
            op(yi, yd, xr, 0, k % 5 == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
